// File: rtl/exa_crosb_pkg.sv
// exa_crosb_pkg -- shared types, widths and helpers for the ExaNet crossbar arbiters.
// rev 1.0
`default_nettype none

package exa_crosb_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PRIO_NUM   = 2;
  localparam int DEF_VC_NUM     = 2;
  localparam int DEF_OUTPUT_NUM = 4;
  localparam int DEF_N_CH       = DEF_PRIO_NUM * DEF_VC_NUM;
  localparam int DEF_CH_W       = clog2_min1(DEF_N_CH);
  localparam int DEF_OUT_W      = clog2_min1(DEF_OUTPUT_NUM);
  localparam int DEF_VC_W       = clog2_min1(DEF_VC_NUM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int ch_idx(input int prio, input int vc, input int vc_num);
    return prio * vc_num + vc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exa_crosb_rr_pick.sv
// exa_crosb_rr_pick -- round-robin picker: first set request at or after the pointer.
// rev 1.0
`default_nettype none

module exa_crosb_rr_pick #(
  parameter int  WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [WIDTH-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = '0;
    for (int k = 0; k < WIDTH; k++) begin
      j = IDX_W'((int'(i_ptr) + k) % WIDTH);
      if (!o_valid && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = j;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/exa_crosb_input_arbiter_with_vcs.sv
// exa_crosb_input_arbiter_with_vcs -- per-input crossbar arbiter: builds per-output VC
// requests, accepts one grant, confirms it with cts and streams the packet. rev 1.0
`default_nettype none

module exa_crosb_input_arbiter_with_vcs
  import exa_crosb_pkg::*;
#(
  parameter int  PRIO_NUM   = DEF_PRIO_NUM,
  parameter int  VC_NUM     = DEF_VC_NUM,
  parameter int  OUTPUT_NUM = DEF_OUTPUT_NUM,
  localparam int N_CH       = PRIO_NUM * VC_NUM,
  localparam int CH_W       = clog2_min1(N_CH),
  localparam int OUT_W      = clog2_min1(OUTPUT_NUM),
  localparam int VC_W       = clog2_min1(VC_NUM),
  localparam int PRIO_W     = clog2_min1(PRIO_NUM)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_CH-1:0]       i_valid,
  input  logic [OUT_W-1:0]      i_dest [N_CH],
  input  logic [N_CH-1:0]       i_last,
  input  logic [OUTPUT_NUM-1:0] i_grant,
  input  logic [OUTPUT_NUM-1:0] i_out_ready,
  output logic [N_CH-1:0]       o_request [OUTPUT_NUM],
  output logic [OUTPUT_NUM-1:0] o_cts,
  output logic [N_CH-1:0]       o_pop,
  output logic [CH_W-1:0]       o_ch_sel,
  output logic [OUT_W-1:0]      o_out_sel,
  output logic                  o_flit_valid,
  output logic                  o_last
);

  state_e                state_q, state_d;
  logic [OUT_W-1:0]      out_ptr_q, out_ptr_d;
  logic [OUT_W-1:0]      out_sel_q, out_sel_d;
  logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
  logic [OUTPUT_NUM-1:0] cts_q, cts_d;
  logic [N_CH-1:0]       pop_mask_q, pop_mask_d;
  logic [VC_W-1:0]       vc_ptr_q [PRIO_NUM];
  logic [VC_W-1:0]       vc_ptr_d [PRIO_NUM];

  logic                  idle;
  logic [N_CH-1:0]       req_raw [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] gnt_vec;

  // Requests are only offered while idle and out of reset; a grant counts only
  // when this input actually asked that output for something.
  assign idle = (state_q == IDLE) && resetn;

  always_comb begin
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int c = 0; c < N_CH; c++) begin
        req_raw[o][c] = idle && i_valid[c] && (i_dest[c] == OUT_W'(o));
      end
      gnt_vec[o] = i_grant[o] && (|req_raw[o]);
    end
  end

  assign o_request = req_raw;

  logic [OUTPUT_NUM-1:0] out_win_oh;
  logic [OUT_W-1:0]      out_win_idx;
  logic                  out_win_valid;

  exa_crosb_rr_pick #(.WIDTH(OUTPUT_NUM)) u_out_pick (
    .i_req   (gnt_vec),
    .i_ptr   (out_ptr_q),
    .o_grant (out_win_oh),
    .o_idx   (out_win_idx),
    .o_valid (out_win_valid)
  );

  logic [N_CH-1:0]     win_req;
  logic [N_CH-1:0]     vc_oh_all;
  logic [VC_W-1:0]     vc_idx [PRIO_NUM];
  logic [PRIO_NUM-1:0] prio_has_req;

  assign win_req = req_raw[out_win_idx];

  generate
    for (genvar p = 0; p < PRIO_NUM; p++) begin : g_prio
      exa_crosb_rr_pick #(.WIDTH(VC_NUM)) u_vc_pick (
        .i_req   (win_req[p*VC_NUM +: VC_NUM]),
        .i_ptr   (vc_ptr_q[p]),
        .o_grant (vc_oh_all[p*VC_NUM +: VC_NUM]),
        .o_idx   (vc_idx[p]),
        .o_valid (prio_has_req[p])
      );
    end
  endgenerate

  logic [PRIO_W-1:0] win_prio;
  logic [VC_W-1:0]   win_vc;
  logic [CH_W-1:0]   win_ch;
  logic [N_CH-1:0]   win_ch_oh;

  // Highest-numbered priority level with a request wins.
  always_comb begin
    win_prio  = '0;
    win_ch_oh = '0;
    for (int p = 0; p < PRIO_NUM; p++) begin
      if (prio_has_req[p]) win_prio = PRIO_W'(p);
    end
    win_vc = vc_idx[win_prio];
    win_ch = CH_W'(ch_idx(int'(win_prio), int'(win_vc), VC_NUM));
    for (int p = 0; p < PRIO_NUM; p++) begin
      if (PRIO_W'(p) == win_prio) win_ch_oh[p*VC_NUM +: VC_NUM] = vc_oh_all[p*VC_NUM +: VC_NUM];
    end
  end

  logic flit;
  logic flit_last;

  assign flit      = (state_q == XFER) && i_valid[ch_sel_q] && i_out_ready[out_sel_q];
  assign flit_last = flit && i_last[ch_sel_q];

  always_comb begin
    state_d    = state_q;
    out_ptr_d  = out_ptr_q;
    out_sel_d  = out_sel_q;
    ch_sel_d   = ch_sel_q;
    cts_d      = cts_q;
    pop_mask_d = pop_mask_q;
    vc_ptr_d   = vc_ptr_q;
    case (state_q)
      IDLE: begin
        if (out_win_valid) begin
          state_d    = XFER;
          out_sel_d  = out_win_idx;
          ch_sel_d   = win_ch;
          cts_d      = out_win_oh;
          pop_mask_d = win_ch_oh;
          out_ptr_d  = (out_win_idx == OUT_W'(OUTPUT_NUM - 1)) ? '0 : out_win_idx + 1'b1;
          vc_ptr_d[win_prio] = (win_vc == VC_W'(VC_NUM - 1)) ? '0 : win_vc + 1'b1;
        end
      end
      XFER: begin
        if (flit_last) begin
          state_d = IDLE;
          cts_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cts_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      out_ptr_q  <= '0;
      out_sel_q  <= '0;
      ch_sel_q   <= '0;
      cts_q      <= '0;
      pop_mask_q <= '0;
      for (int p = 0; p < PRIO_NUM; p++) vc_ptr_q[p] <= '0;
    end else begin
      state_q    <= state_d;
      out_ptr_q  <= out_ptr_d;
      out_sel_q  <= out_sel_d;
      ch_sel_q   <= ch_sel_d;
      cts_q      <= cts_d;
      pop_mask_q <= pop_mask_d;
      for (int p = 0; p < PRIO_NUM; p++) vc_ptr_q[p] <= vc_ptr_d[p];
    end
  end

  assign o_cts        = cts_q;
  assign o_pop        = flit ? pop_mask_q : '0;
  assign o_flit_valid = flit;
  assign o_last       = flit_last;
  assign o_ch_sel     = ch_sel_q;
  assign o_out_sel    = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_exa_crosb_input_arbiter_with_vcs.sv
// tb_exa_crosb_input_arbiter_with_vcs -- directed bench for the per-input VC arbiter.
// rev 1.0
`default_nettype none

module tb_exa_crosb_input_arbiter_with_vcs;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] valid;
  logic [1:0] dest [4];
  logic [3:0] in_last;
  logic [3:0] grant;
  logic [3:0] ready;
  logic [3:0] req [4];
  logic [3:0] o_cts;
  logic [3:0] o_pop;
  logic [1:0] o_ch_sel;
  logic [1:0] o_out_sel;
  logic       o_flit_valid;
  logic       o_last;

  int tests = 0;
  int fails = 0;
  int exp_vc [3] = '{2, 3, 2};

  always #5 clk = ~clk;

  exa_crosb_input_arbiter_with_vcs dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_valid      (valid),
    .i_dest       (dest),
    .i_last       (in_last),
    .i_grant      (grant),
    .i_out_ready  (ready),
    .o_request    (req),
    .o_cts        (o_cts),
    .o_pop        (o_pop),
    .o_ch_sel     (o_ch_sel),
    .o_out_sel    (o_out_sel),
    .o_flit_valid (o_flit_valid),
    .o_last       (o_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] req_flat();
    return {req[3], req[2], req[1], req[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    valid   = '0;
    in_last = '0;
    grant   = '0;
    ready   = 4'hF;
    for (int i = 0; i < 4; i++) dest[i] = '0;

    // Reset state
    resetn = 1'b0;
    tick(); tick(); #1;
    chk("rst_cts", o_cts, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_fv", o_flit_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ch_sel", o_ch_sel, 0);
    chk("rst_out_sel", o_out_sel, 0);
    chk("rst_req", req_flat(), 0);
    resetn = 1'b1;

    // Single 3-flit packet: ch1 -> output 2
    tick();
    valid = 4'b0010; dest[1] = 2'd2; grant = 4'b0100; #1;
    chk("sp_req", req_flat(), 16'h0200);
    chk("sp_idle_cts", o_cts, 0);
    chk("sp_idle_pop", o_pop, 0);
    tick(); grant = '0; #1;
    chk("sp_f1_cts", o_cts, 4'b0100);
    chk("sp_f1_pop", o_pop, 4'b0010);
    chk("sp_f1_ch", o_ch_sel, 1);
    chk("sp_f1_out", o_out_sel, 2);
    chk("sp_f1_last", o_last, 0);
    chk("sp_xfer_req", req_flat(), 0);
    tick(); #1;
    chk("sp_f2_pop", o_pop, 4'b0010);
    chk("sp_f2_last", o_last, 0);
    tick(); in_last = 4'b0010; #1;
    chk("sp_f3_pop", o_pop, 4'b0010);
    chk("sp_f3_last", o_last, 1);
    chk("sp_f3_cts", o_cts, 4'b0100);
    tick(); valid = '0; in_last = '0; #1;
    chk("sp_idle_after", o_cts, 0);

    // Priority: ch0 and ch2 both to output 1, prio1 wins
    tick();
    valid = 4'b0101; dest[0] = 2'd1; dest[2] = 2'd1; grant = 4'b0010; #1;
    chk("pr_req", req_flat(), 16'h0050);
    tick(); grant = '0; in_last = 4'b0100; #1;
    chk("pr_ch", o_ch_sel, 2);
    chk("pr_out", o_out_sel, 1);
    chk("pr_cts", o_cts, 4'b0010);
    chk("pr_pop", o_pop, 4'b0100);
    chk("pr_last", o_last, 1);
    tick(); valid = '0; in_last = '0; #1;
    chk("pr_idle", o_cts, 0);

    // Reset during XFER
    tick();
    valid = 4'b1000; dest[3] = 2'd3; grant = 4'b1000; #1;
    tick(); grant = '0; #1;
    chk("rx_cts", o_cts, 4'b1000);
    chk("rx_ch", o_ch_sel, 3);
    chk("rx_pop", o_pop, 4'b1000);
    resetn = 1'b0;
    tick(); #1;
    chk("rx_cts0", o_cts, 0);
    chk("rx_pop0", o_pop, 0);
    chk("rx_fv0", o_flit_valid, 0);
    chk("rx_ch0", o_ch_sel, 0);
    chk("rx_out0", o_out_sel, 0);
    chk("rx_req0", req_flat(), 0);
    resetn = 1'b1; #1;
    chk("rx_idle_req", req_flat(), 16'h8000);
    valid = '0;

    // Output fairness: outputs 0 and 3 granted together twice
    tick();
    valid = 4'b1001; dest[0] = 2'd0; dest[3] = 2'd3; grant = 4'b1001; in_last = 4'b0001; #1;
    chk("of_req", req_flat(), 16'h8001);
    tick(); grant = '0; #1;
    chk("of_cts1", o_cts, 4'b0001);
    chk("of_ch1", o_ch_sel, 0);
    chk("of_last1", o_last, 1);
    tick(); grant = 4'b1001; #1;
    chk("of_gap_cts", o_cts, 0);
    tick(); grant = '0; in_last = 4'b1000; #1;
    chk("of_cts2", o_cts, 4'b1000);
    chk("of_ch2", o_ch_sel, 3);
    chk("of_last2", o_last, 1);
    tick(); valid = '0; in_last = '0; #1;
    chk("of_idle", o_cts, 0);

    // VC fairness: ch2/ch3 single-flit packets to output 0
    valid = 4'b1100; dest[2] = 2'd0; dest[3] = 2'd0; in_last = 4'b1100; grant = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("vc_ch", o_ch_sel, exp_vc[i]);
      chk("vc_cts", o_cts, 4'b0001);
      chk("vc_last", o_last, 1);
      tick(); #1;
      chk("vc_idle_cts", o_cts, 0);
    end
    grant = '0; valid = '0; in_last = '0;

    // Backpressure then bubble mid-packet, 4 flits ch1 -> output 2
    tick();
    valid = 4'b0010; dest[1] = 2'd2; grant = 4'b0100; #1;
    tick(); grant = '0; #1;
    chk("bp_f1_pop", o_pop, 4'b0010);
    chk("bp_f1_cts", o_cts, 4'b0100);
    tick(); ready = 4'b1011; #1;
    chk("bp_s1_pop", o_pop, 0);
    chk("bp_s1_fv", o_flit_valid, 0);
    chk("bp_s1_cts", o_cts, 4'b0100);
    tick(); #1;
    chk("bp_s2_pop", o_pop, 0);
    tick(); ready = 4'hF; valid = '0; #1;
    chk("bp_bub_pop", o_pop, 0);
    chk("bp_bub_cts", o_cts, 4'b0100);
    tick(); valid = 4'b0010; #1;
    chk("bp_f2_pop", o_pop, 4'b0010);
    chk("bp_f2_last", o_last, 0);
    tick(); #1;
    chk("bp_f3_pop", o_pop, 4'b0010);
    chk("bp_f3_last", o_last, 0);
    tick(); in_last = 4'b0010; #1;
    chk("bp_f4_pop", o_pop, 4'b0010);
    chk("bp_f4_last", o_last, 1);
    tick(); valid = '0; in_last = '0; #1;
    chk("bp_idle", o_cts, 0);

    // Spurious grant to an output with no request
    tick();
    valid = 4'b0001; dest[0] = 2'd1; grant = 4'b1000; #1;
    chk("sg_req", req_flat(), 16'h0010);
    tick(); grant = '0; #1;
    chk("sg_cts", o_cts, 0);
    chk("sg_ch_hold", o_ch_sel, 1);
    chk("sg_out_hold", o_out_sel, 2);
    chk("sg_still_idle", req_flat(), 16'h0010);
    valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exa_crosb_input_arbiter_with_vcs.md
# exa_crosb_input_arbiter_with_vcs

Per-input-port arbiter of the ExaNet crossbar, directly upstream of the per-output arbiters. It turns the head-of-line status of the port's VC FIFOs into per-output request vectors and accepts exactly one of the grants that come back. It confirms that grant with cts, then streams the packet's flits from the chosen VC FIFO to the crossbar until the last flit. One instance exists per crossbar input; its `o_request[o]` and `o_cts[o]` connect to output arbiter `o`.

## Interface
- `prio_num`, 2: priority levels.
- `vc_num`, 2: VCs per priority. Channel index ch = prio*vc_num + vc; N = vc_num*prio_num.
- `output_num`, 4: crossbar outputs.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `i_valid`  in  N  head flit present in VC FIFO ch.
- `i_dest[N]`  in  $clog2(output_num) each  destination output of the head packet of ch. Valid only while `i_valid[ch]`.
- `i_last`  in  N  head flit of ch is the packet's last flit.
- `i_grant`  in  output_num  this input's grant bit from each output arbiter (combinational, same cycle as the request).
- `i_out_ready`  in  output_num  output o can take a flit this cycle.
- `o_request[output_num]`  out  N each  per-output channel request vector.
- `o_cts`  out  output_num  one-hot confirm to the accepted output arbiter.
- `o_pop`  out  N  one-hot dequeue strobe to the VC FIFOs.
- `o_ch_sel`  out  $clog2(N)  locked channel (crossbar data mux select).
- `o_out_sel`  out  $clog2(output_num)  locked output.
- `o_flit_valid`  out  1  flit forwarded this cycle.
- `o_last`  out  1  forwarded flit is the last one; feeds the output arbiter's `i_last`.

## Operation
- Two states: IDLE and XFER. Reset puts the block in IDLE, clears all outputs to 0, and clears the output and VC round-robin pointers to 0.
- **IDLE, requests:** `o_request[o][ch] = i_valid[ch] & (i_dest[ch]==o)`. All of `o_cts`, `o_pop`, `o_flit_valid` and `o_last` are 0.
- **IDLE, accepting a grant:** a grant bit counts only if its output has a non-zero request vector this cycle; other grant bits are ignored.
  - Among the counted grants, the output winner is chosen round-robin starting from `out_ptr`.
  - Within the winning output's requests, the channel winner comes from the highest priority level that has a request, round-robin over its VCs starting from `vc_ptr[prio]`.
- **On acceptance:** latch out_sel and ch_sel, set `out_ptr` = winner+1 mod output_num, set `vc_ptr[prio]` = winning vc+1 mod vc_num, and go to XFER.
- **XFER:**
  - `o_request` is all 0, so no new grants are taken.
  - `o_cts[out_sel]` = 1.
  - `o_pop[ch_sel] = o_flit_valid = i_valid[ch_sel] & i_out_ready[out_sel]`.
  - `o_last = o_flit_valid & i_last[ch_sel]`.
  - `o_last` = 1 returns the block to IDLE on the next cycle.
- **XFER stalls:** if `i_valid[ch_sel]` is low or `i_out_ready[out_sel]` is low, no flit moves and the state holds. There is no timeout.
- **Single-flit packet:** the flit moves in the first XFER cycle with `o_last` = 1, giving one XFER cycle in total.
- **Reset mid-XFER:** `o_cts` drops in the next cycle and the packet is abandoned. Cleanup is the owner of the FIFO's responsibility.
- `o_ch_sel` and `o_out_sel` hold their latched values in IDLE.

## Timing
- Grant in cycle t (IDLE) → `o_cts` high at t+1. This matches the output arbiter entering GRANTED at t+1. An output whose grant was not accepted sees `cts` = 0 at t+1 and returns to its IDLE.
- First flit can move at t+1.
- Last flit popped at cycle u → IDLE at u+1, with requests visible at u+1. The earliest re-grant is at u+1, so the gap between packets is one cycle.
- All outputs except `o_request` are registered or decoded from state plus the current `i_valid`/`i_out_ready`.
- `o_request` is combinational from `i_valid`/`i_dest` in IDLE.

## Structure
- Shared package `exa_crosb_pkg`:
  - state enum {IDLE, XFER}
  - channel-index helper (prio, vc → ch)
  - width localparams derived from `prio_num`, `vc_num` and `output_num`.
- Sub-module `exa_crosb_rr_pick`: a parameterized-width round-robin picker (request vector + pointer → one-hot winner + binary index). It is instantiated once for outputs and once per priority level for VCs.

## Test plan
- **Single packet:** ch1 (prio0, vc1) valid, dest=2, 3 flits, out_ready=1, grant[2] at t → `o_cts`=4'b0100 at t+1..t+3, `o_pop`=4'b0010 for 3 cycles, `o_last` at t+3, IDLE at t+4.
- **Priority:** ch0 dest1 and ch2 (prio1) dest1, grant[1] → ch_sel=2.
- **Output fairness:** ch0 dest0 and ch3 dest3, both granted in the same cycle → first winner is output 0 with `o_cts`=4'b0001. Next round, both granted again → output 3.
- **VC fairness:** ch2 and ch3 (prio1) both dest0, grant[0] repeated → ch_sel alternates 2, 3, 2.
- **Backpressure and bubble:** out_ready low for 2 cycles and then `i_valid` low for 1 cycle mid-packet → no pop in those cycles, `cts` stays high, and flit order is preserved.
- **Edge cases:**
  - Spurious grant[3] with no request to output 3 → ignored, stays IDLE.
  - resetn low during XFER → all outputs 0 next cycle, IDLE.
